// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives trial codes into the DAC and
// binary-searches the sampled input one bit per settle window using the comparator.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp,
    output logic             sample,
    output logic             dac_ena,
    output logic [WIDTH-1:0] dac_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int TCW = $clog2(SETTLE_CYCLES);
    localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [SCW-1:0]   SAMPLE_LOAD = SCW'(SAMPLE_CYCLES - 1);
    localparam logic [TCW-1:0]   SETTLE_LOAD = TCW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0]    MSB_IDX     = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE    = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             cmp_meta_q, cmp_meta_d;
    logic             cmp_s_q, cmp_s_d;
    logic [SCW-1:0]   samp_cnt_q, samp_cnt_d;
    logic [TCW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             sample_q, sample_d;
    logic             dac_ena_q, dac_ena_d;
    logic [WIDTH-1:0] dac_data_q, dac_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] resolved;

    function automatic logic [WIDTH-1:0] bit_mask(input logic [IW-1:0] idx);
        return WIDTH'(1) << idx;
    endfunction

    // A trial bit survives only if the input is at or above the trial code.
    function automatic logic [WIDTH-1:0] resolve_bit(input logic [WIDTH-1:0] code,
                                                     input logic [IW-1:0]    idx,
                                                     input logic             keep);
        return keep ? code : (code & ~bit_mask(idx));
    endfunction

    always_comb begin
        state_d      = state_q;
        cmp_meta_d   = cmp;
        cmp_s_d      = cmp_meta_q;
        samp_cnt_d   = samp_cnt_q;
        settle_cnt_d = settle_cnt_q;
        idx_d        = idx_q;
        sample_d     = sample_q;
        dac_ena_d    = en;
        dac_data_d   = dac_data_q;
        done_d       = 1'b0;
        result_d     = result_q;
        resolved     = resolve_bit(dac_data_q, idx_q, cmp_s_q);

        case (state_q)
            ST_IDLE: begin
                if (start && en) begin
                    state_d    = ST_SAMPLE;
                    samp_cnt_d = SAMPLE_LOAD;
                    sample_d   = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (samp_cnt_q == '0) begin
                    state_d      = ST_CONVERT;
                    sample_d     = 1'b0;
                    idx_d        = MSB_IDX;
                    dac_data_d   = MSB_CODE;
                    settle_cnt_d = SETTLE_LOAD;
                end else begin
                    samp_cnt_d = samp_cnt_q - SCW'(1);
                end
            end
            ST_CONVERT: begin
                if (settle_cnt_q == '0) begin
                    if (idx_q == '0) begin
                        state_d    = ST_DONE;
                        dac_data_d = resolved;
                        result_d   = resolved;
                        done_d     = 1'b1;
                    end else begin
                        dac_data_d   = resolved | bit_mask(idx_q - IW'(1));
                        idx_d        = idx_q - IW'(1);
                        settle_cnt_d = SETTLE_LOAD;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q - TCW'(1);
                end
            end
            ST_DONE: begin
                if (cont && en) begin
                    state_d    = ST_SAMPLE;
                    samp_cnt_d = SAMPLE_LOAD;
                    sample_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping enable abandons any conversion in flight without touching result.
        if (state_q != ST_IDLE && !en) begin
            state_d    = ST_IDLE;
            sample_d   = 1'b0;
            dac_data_d = '0;
            done_d     = 1'b0;
            result_d   = result_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmp_meta_q   <= 1'b0;
            cmp_s_q      <= 1'b0;
            samp_cnt_q   <= '0;
            settle_cnt_q <= '0;
            idx_q        <= '0;
            sample_q     <= 1'b0;
            dac_ena_q    <= 1'b0;
            dac_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            cmp_meta_q   <= cmp_meta_d;
            cmp_s_q      <= cmp_s_d;
            samp_cnt_q   <= samp_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            idx_q        <= idx_d;
            sample_q     <= sample_d;
            dac_ena_q    <= dac_ena_d;
            dac_data_q   <= dac_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
        end
    end

    assign sample   = sample_q;
    assign dac_ena  = dac_ena_q;
    assign dac_data = dac_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Successive-approximation controller that turns the 8-bit DAC into an ADC. It drives a trial code into the DAC, reads back an external analog comparator that compares the sampled input against the DAC output, and binary-searches one bit per step. The result is a held 8-bit code plus a one-cycle `done` pulse. It sits between the register/bus logic and the `dac_3v_8bit` + comparator + sample/hold analog macros.

## Interface
- `WIDTH`, 8: conversion resolution; equals the DAC data width.
- `SAMPLE_CYCLES`, 4: cycles `sample` stays high per conversion; must be ≥1.
- `SETTLE_CYCLES`, 4: cycles per bit trial, covering DAC settling plus the 2-flop `cmp` synchronizer; must be ≥3.
- `clk`  in  1  block clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  block enable; drives `dac_ena`; deassertion aborts a conversion.
- `start`  in  1  conversion request, sampled in IDLE only.
- `cont`  in  1  continuous mode: the next conversion starts automatically after DONE.
- `cmp`  in  1  asynchronous comparator output; 1 means Vin ≥ Vdac.
- `sample`  out  1  sample/hold control; high means track.
- `dac_ena`  out  1  DAC enable; registered copy of `en`.
- `dac_data`  out  WIDTH  trial code to the DAC.
- `busy`  out  1  high in SAMPLE, CONVERT and DONE.
- `done`  out  1  one-cycle pulse when `result` updates.
- `result`  out  WIDTH  last completed conversion; held until the next completion.

## Operation
- `cmp` passes through a 2-flop synchronizer to produce `cmp_s`. This is the only path from `cmp` into the logic.
- FSM states: IDLE, SAMPLE, CONVERT, DONE.
- IDLE: `sample`=0, `busy`=0. If `start && en` → SAMPLE, load sample counter with SAMPLE_CYCLES-1, and register `sample`=1.
- SAMPLE: `sample`=1. When the counter reaches 0:
  - go to CONVERT;
  - `sample`=0;
  - bit index = WIDTH-1;
  - `dac_data` = 1<<(WIDTH-1);
  - settle counter = SETTLE_CYCLES-1.
- CONVERT: decrement the settle counter. When it reaches 0:
  - if `cmp_s`=0, clear `dac_data[idx]`; if 1, keep it;
  - if idx=0 → DONE;
  - otherwise set `dac_data[idx-1]`, decrement idx, and reload the settle counter.
- DONE, one cycle:
  - `result` ← `dac_data`;
  - `done`=1;
  - if `cont && en` → SAMPLE with the counter reloaded; otherwise → IDLE.
- `dac_data` holds the final code after DONE until the next SAMPLE→CONVERT transition.
- `start` outside IDLE is ignored. It is not queued.
- `en`=0 in any non-IDLE state → IDLE on the next edge:
  - `sample`=0, `dac_data`=0;
  - no `done` pulse;
  - `result` unchanged.
- `en` and `start` are checked together in IDLE. `start` with `en`=0 is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `sample`=0, `dac_ena`=0, `dac_data`=0, `busy`=0, `done`=0, `result`=0;
  - synchronizer flops and all counters = 0.
- `rst` mid-conversion returns the FSM to IDLE on that edge with all outputs at their reset values. `result` is also cleared.
- If `start` is sampled high in cycle 0, then:
  - `sample` is high in cycles 1..SAMPLE_CYCLES;
  - bit trial k (k=0 for the MSB) occupies cycles SAMPLE_CYCLES+1+k·SETTLE_CYCLES through SAMPLE_CYCLES+(k+1)·SETTLE_CYCLES;
  - `done` is high in cycle SAMPLE_CYCLES + WIDTH·SETTLE_CYCLES + 1. With defaults this is cycle 37.
- The bit decision uses `cmp_s` in the last cycle of each trial. `cmp` must therefore be valid from 2 cycles before that point.
- `result` updates on the same edge that raises `done`.
- In continuous mode `sample` rises the cycle after `done`, so the conversion period is SAMPLE_CYCLES + WIDTH·SETTLE_CYCLES + 1 cycles (37 with defaults).
- `dac_ena` follows `en` with 1 cycle of latency.

## Test plan
- Comparator model `cmp = (vin_code >= dac_data)` with vin_code=0xA5; `en`=1, pulse `start` → `done` in cycle 37, `result`=0xA5, and `dac_data` trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- Boundary codes: vin_code=0x00 → `result`=0x00; vin_code=0xFF → `result`=0xFF; vin_code=0x80 → `result`=0x80.
- `cont`=1 with vin_code stepping 0x10 → 0x20: back-to-back `done` pulses 37 cycles apart, `result` 0x10 then 0x20, and `busy` never drops.
- `start` pulsed again in cycle 10 of a conversion → ignored: a single `done` pulse in cycle 37.
- Abort: drop `en` in cycle 20 → next cycle `busy`=0, `dac_data`=0, no `done`, `result` keeps its previous value; `dac_ena`=0 one cycle after `en` drops.
- Assert `rst` in cycle 15 → all outputs 0 on the next edge; a fresh `start` afterwards converts normally.
